// File: rtl/axil_pkg.sv
// Shared constants for the AXI4-Lite SRAM responder: response codes, FSM
// state encoding, LFSR seed and a byte-strobe merge helper.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_RD_RESP = 3'd2;
  localparam logic [2:0] ST_WR_WAIT = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_WAIT = ST_RD_WAIT,
    RD_RESP = ST_RD_RESP,
    WR_WAIT = ST_WR_WAIT,
    WR_RESP = ST_WR_RESP
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_sram_resp_if.sv
// AXI4-Lite read/write channel bundle between the core (master) and the
// SRAM responder (slave).
interface axil_sram_resp_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axil_lfsr8.sv
// Random extra-delay source: 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances
// every cycle; the low two bits give 0..3 extra response cycles.
module axil_lfsr8
  import axil_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] extra
);
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign extra = lfsr_q[1:0];
endmodule

// File: rtl/axil_sram_resp.sv
// AXI4-Lite responder in front of an inferred word-addressed SRAM, one
// transaction at a time with LATENCY extra response cycles. Optional random
// extra delay is enabled by defining AXIL_SRAM_RAND_DELAY_EN.
module axil_sram_resp
  import axil_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0]    BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned          LATENCY    = 1
) (
  input  logic             clk,
  input  logic             rst,
  axil_sram_resp_if.slave  bus
);
  localparam int unsigned       DEPTH = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W:0]   SPAN  = (ADDR_W + 1)'(4) << DEPTH_LOG2;
`ifdef AXIL_SRAM_RAND_DELAY_EN
  // Room for LATENCY (max 15) plus up to 3 random cycles.
  localparam int unsigned CNT_W = 5;
`else
  localparam int unsigned CNT_W = 4;
`endif

  state_e state_q, next_state;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic [1:0]        bresp_q;

  logic              rd_hs, wr_hs;
  logic              rd_enter, wr_enter;
  logic [CNT_W-1:0]  total_lat;
  logic [ADDR_W-1:0] hs_addr, cur_addr, offset;
  logic [DATA_W-1:0] cur_wdata;
  logic [3:0]        cur_wstrb;
  logic              in_range;
  logic [DEPTH_LOG2-1:0] cur_idx;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef AXIL_SRAM_RAND_DELAY_EN
  logic [1:0] extra;

  axil_lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .extra (extra)
  );

  assign total_lat = CNT_W'(LATENCY) + CNT_W'(extra);
`else
  assign total_lat = CNT_W'(LATENCY);
`endif

  // During IDLE the transaction comes straight off the bus (zero-latency
  // path); afterwards it comes from the latched copy.
  assign hs_addr   = rd_hs ? bus.araddr : bus.awaddr;
  assign cur_addr  = (state_q == IDLE) ? hs_addr   : addr_q;
  assign cur_wdata = (state_q == IDLE) ? bus.wdata : wdata_q;
  assign cur_wstrb = (state_q == IDLE) ? bus.wstrb : wstrb_q;

  // Compare with one spare bit so BASE_ADDR + span cannot wrap.
  assign offset   = cur_addr - BASE_ADDR;
  assign in_range = (cur_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign cur_idx  = offset[DEPTH_LOG2+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value held and no latch is inferred.
    next_state  = state_q;
    rd_hs       = 1'b0;
    wr_hs       = 1'b0;
    bus.arready = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst) begin
          bus.arready = 1'b1;
          if (bus.arvalid) begin
            rd_hs      = 1'b1;
            next_state = (total_lat == '0) ? RD_RESP : RD_WAIT;
          end else if (bus.awvalid && bus.wvalid) begin
            bus.awready = 1'b1;
            bus.wready  = 1'b1;
            wr_hs       = 1'b1;
            next_state  = (total_lat == '0) ? WR_RESP : WR_WAIT;
          end
        end
      end
      RD_WAIT: if (cnt_q == '0) next_state = RD_RESP;
      RD_RESP: if (bus.rready)  next_state = IDLE;
      WR_WAIT: if (cnt_q == '0) next_state = WR_RESP;
      WR_RESP: if (bus.bready)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign rd_enter = (next_state == RD_RESP) && (state_q != RD_RESP);
  assign wr_enter = (next_state == WR_RESP) && (state_q != WR_RESP);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      if (rd_hs || wr_hs) begin
        addr_q  <= hs_addr;
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
        cnt_q   <= total_lat - 1'b1;
      end else if ((state_q == RD_WAIT || state_q == WR_WAIT) && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (rd_enter) begin
        rdata_q <= in_range ? mem[cur_idx] : '0;
        rresp_q <= in_range ? RESP_OKAY : RESP_DECERR;
      end
      if (wr_enter) begin
        bresp_q <= in_range ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // NOTE: the SRAM array has no reset; contents survive rst and only the
  // control path is cleared, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_enter && in_range) begin
      mem[cur_idx] <= apply_strb(mem[cur_idx], cur_wdata, cur_wstrb);
    end
  end

  assign bus.rvalid = (state_q == RD_RESP);
  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;
  assign bus.bvalid = (state_q == WR_RESP);
  assign bus.bresp  = bresp_q;

endmodule

// File: doc/axil_sram_resp.md
Name: axil_sram_resp

Overview:
- AXI4-Lite responder that serves the core's instruction-fetch and load/store accesses from an on-chip word-addressed SRAM array.
- It is the memory end of the bus that replaces the current combinational fetch and data-memory path.
- It accepts one transaction at a time and inserts configurable response latency, so the core's handshake logic is exercised.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, with 4 strobe bits.
- DEPTH_LOG2, 12, log2 of the word count (4096 words = 16 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 1, cycles from the address handshake to the response valid, minus 1; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- araddr  in  ADDR_W  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response code.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  ADDR_W  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_W  write data.
- wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response code.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; rvalid=bvalid=0; rdata=0; rresp=bresp=2'b00.
  - arready/awready/wready are forced 0 while rst=1.
  - SRAM contents are not reset.
- States: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- IDLE:
  - arready=1; awready=wready=(awvalid&wvalid).
  - Writes are accepted only when AW and W are both valid in the same cycle.
  - If arvalid and (awvalid&wvalid) are both high, the read wins; the write readies stay 0 that cycle.
  - A read handshake latches araddr and goes to RD_WAIT, or directly to RD_RESP if LATENCY=0.
  - A write handshake latches awaddr/wdata/wstrb and goes to WR_WAIT, or to WR_RESP if LATENCY=0.
- In all non-IDLE states, arready=awready=wready=0.
- WAIT states: a 4-bit counter is loaded with LATENCY-1 at the handshake and decrements each cycle. When it reaches 0, the block moves to the RESP state.
- Net latency: for a handshake at edge T, rvalid/bvalid rise at edge T+1+LATENCY.
- Decode:
  - word index = (addr-BASE_ADDR)>>2; addr[1:0] is ignored.
  - An address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^DEPTH_LOG2.
- Read:
  - In range: rdata=mem[index], rresp=OKAY (2'b00).
  - Out of range: rdata=0, rresp=DECERR (2'b11).
  - rdata/rresp are registered on entry to RD_RESP and held stable while rvalid=1.
- Write:
  - The SRAM is updated on the edge that enters WR_RESP, bytewise per wstrb.
  - wstrb=0 is OKAY with no change.
  - Out of range: no write, bresp=DECERR.
- RESP states hold valid until the matching ready is high. On rvalid&rready (or bvalid&bready), valid drops next cycle and the state returns to IDLE.
- Back-to-back: the earliest next address handshake is the cycle after the response handshake (IDLE lasts at least 1 cycle).
- Read-after-write: a read accepted after the bvalid handshake returns the new data.
- Reset mid-transaction: any pending response is dropped and the state returns to IDLE. If the update edge has not occurred, the SRAM is not written.

Optional Feature:
- Macro AXIL_SRAM_RAND_DELAY_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset) advances every cycle.
  - At each address handshake, lfsr[1:0] (0..3) extra cycles are added to the counter load.
  - Latency becomes T+1+LATENCY+extra.
- When undefined: fixed latency, and no LFSR logic is present.

Decomposition:
- Shared package axil_pkg:
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - state encoding localparams for the 5 states;
  - LFSR seed constant.
- One natural sub-module: axil_lfsr8 (the delay generator), instantiated only under AXIL_SRAM_RAND_DELAY_EN.
- The SRAM array is inferred inline.

Test Plan:
- Reset with LATENCY=1:
  - Stimulus: write 0x8000_0000 data 0xDEAD_BEEF, wstrb 4'hF, bready=1.
  - Required: bvalid at T+2, bresp=00.
  - Stimulus: then read the same address.
  - Required: rvalid at T+2, rdata=0xDEAD_BEEF, rresp=00.
- Partial write:
  - Stimulus: write 0x1122_3344 with wstrb 4'hF, then write 0xAABB_CCDD with wstrb 4'b0101.
  - Required: a read returns 0x11BB_33DD.
- Simultaneous arvalid and awvalid&wvalid in IDLE:
  - Required: read accepted first (arready=1, awready=0); write accepted after the R handshake.
- Out of range:
  - Stimulus: read 0x7FFF_FFFC; write 0x8001_0000 (DEPTH_LOG2=12).
  - Required: rresp=bresp=11, rdata=0, SRAM unchanged.
- Backpressure and reset:
  - Stimulus: rready=0 for 5 cycles.
  - Required: rvalid and rdata held stable, no new arready.
  - Stimulus: rst pulse during WR_WAIT.
  - Required: bvalid stays 0, memory word unchanged, state IDLE.
- LATENCY=0, and LATENCY=0 with AXIL_SRAM_RAND_DELAY_EN:
  - Required (no macro): rvalid at T+1.
  - Required (with macro): latency equals 1+lfsr[1:0] and matches a reference LFSR model seeded 8'hA5.
